// File: rtl/ps2_keycode_if.sv
// Keycode bus between the PS/2 decoder (master) and the player-movement logic (slave).
`timescale 1ns/1ps

interface ps2_keycode_if;
  localparam int unsigned KEY_W = 8;

  logic [KEY_W-1:0] keycode;      // HID code of the held tracked key, 00 = none
  logic             keycode_chg;  // one-cycle pulse when keycode takes a new value
  logic             frame_err;    // one-cycle pulse on parity/stop/timeout error

  modport master (output keycode, keycode_chg, frame_err);
  modport slave  (input  keycode, keycode_chg, frame_err);
endinterface

// File: rtl/ps2_keycode.sv
// PS/2 set-2 scan-code receiver that translates movement/fire keys to HID usage codes
// and holds the code on the keycode bus while the key is down.
// Optional feature macro: ARROW_KEYS_EN (arrow keys alias W/S/A/D).
`timescale 1ns/1ps

module ps2_keycode #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_keycode_if.master kb
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned TO_W   = 16;

  // Set-2 scan codes of interest
  localparam logic [BYTE_W-1:0] SC_BRK   = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_W     = 8'h1D;
  localparam logic [BYTE_W-1:0] SC_S     = 8'h1B;
  localparam logic [BYTE_W-1:0] SC_A     = 8'h1C;
  localparam logic [BYTE_W-1:0] SC_D     = 8'h23;
  localparam logic [BYTE_W-1:0] SC_SPACE = 8'h29;
`ifdef ARROW_KEYS_EN
  localparam logic [BYTE_W-1:0] SC_UP    = 8'h75;
  localparam logic [BYTE_W-1:0] SC_DOWN  = 8'h72;
  localparam logic [BYTE_W-1:0] SC_LEFT  = 8'h6B;
  localparam logic [BYTE_W-1:0] SC_RIGHT = 8'h74;
`endif

  // HID usage codes
  localparam logic [BYTE_W-1:0] HID_NONE  = 8'h00;
  localparam logic [BYTE_W-1:0] HID_W     = 8'h1A;
  localparam logic [BYTE_W-1:0] HID_S     = 8'h16;
  localparam logic [BYTE_W-1:0] HID_A     = 8'h04;
  localparam logic [BYTE_W-1:0] HID_D     = 8'h07;
  localparam logic [BYTE_W-1:0] HID_SPACE = 8'h2C;

  localparam logic [TO_W-1:0]  TO_LAST  = TIMEOUT - 16'd1;
  localparam logic [CNT_W-1:0] LAST_BIT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Synchronisers; idle PS/2 lines are high, so the flops reset to 1
  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-1:0]   shift, shift_nxt;
  logic                par, par_nxt;
  logic [TO_W-1:0]     to_cnt, to_cnt_nxt;
  logic                brk, brk_nxt;
  logic                ext, ext_nxt;
  logic [BYTE_W-1:0]   keycode_q, keycode_nxt;
  logic                chg_q, chg_nxt;
  logic                err_q, err_nxt;

  logic                fall;
  logic                timeout_hit;
  logic                byte_good;
  logic                trk_hit;
  logic [BYTE_W-1:0]   trk_code;

  // Two-flop synchronisers plus a delayed copy of the clock for edge detection
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

  // A fall cycle restarts the counter, so a timeout never coincides with a frame check
  assign timeout_hit = (state != ST_IDLE) && !fall && (to_cnt == TO_LAST);

  // Translate the received byte (already complete in the shift register at STOP)
  always_comb begin
    trk_hit  = 1'b0;
    trk_code = HID_NONE;
    if (!ext) begin
      case (shift)
        SC_W:     begin trk_hit = 1'b1; trk_code = HID_W;     end
        SC_S:     begin trk_hit = 1'b1; trk_code = HID_S;     end
        SC_A:     begin trk_hit = 1'b1; trk_code = HID_A;     end
        SC_D:     begin trk_hit = 1'b1; trk_code = HID_D;     end
        SC_SPACE: begin trk_hit = 1'b1; trk_code = HID_SPACE; end
        default:  ;
      endcase
    end
`ifdef ARROW_KEYS_EN
    else begin
      case (shift)
        SC_UP:    begin trk_hit = 1'b1; trk_code = HID_W; end
        SC_DOWN:  begin trk_hit = 1'b1; trk_code = HID_S; end
        SC_LEFT:  begin trk_hit = 1'b1; trk_code = HID_A; end
        SC_RIGHT: begin trk_hit = 1'b1; trk_code = HID_D; end
        default:  ;
      endcase
    end
`endif
  end

  // State register and frame/key datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      to_cnt    <= '0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      keycode_q <= HID_NONE;
      chg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      par       <= par_nxt;
      to_cnt    <= to_cnt_nxt;
      brk       <= brk_nxt;
      ext       <= ext_nxt;
      keycode_q <= keycode_nxt;
      chg_q     <= chg_nxt;
      err_q     <= err_nxt;
    end
  end

  // Frame FSM next state, byte check, prefix tracking and key update
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_nxt     = par;
    to_cnt_nxt  = to_cnt + 16'd1;
    brk_nxt     = brk;
    ext_nxt     = ext;
    keycode_nxt = keycode_q;
    err_nxt     = 1'b0;
    byte_good   = 1'b0;

    if (state == ST_IDLE || fall) begin
      to_cnt_nxt = '0;
    end

    if (timeout_hit) begin
      state_nxt  = ST_IDLE;
      to_cnt_nxt = '0;
      err_nxt    = 1'b1;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!data_sync) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          shift_nxt   = {data_sync, shift[BYTE_W-1:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_nxt   = data_sync;
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          state_nxt = ST_IDLE;
          byte_good = data_sync && (^{shift, par});
          if (!byte_good) begin
            err_nxt = 1'b1;
            brk_nxt = 1'b0;
            ext_nxt = 1'b0;
          end else if (shift == SC_BRK) begin
            brk_nxt = 1'b1;
          end else if (shift == SC_EXT) begin
            ext_nxt = 1'b1;
          end else begin
            if (trk_hit) begin
              if (!brk) begin
                keycode_nxt = trk_code;
              end else if (keycode_q == trk_code) begin
                keycode_nxt = HID_NONE;
              end
            end
            brk_nxt = 1'b0;
            ext_nxt = 1'b0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    chg_nxt = (keycode_nxt != keycode_q);
  end

  assign kb.keycode     = keycode_q;
  assign kb.keycode_chg = chg_q;
  assign kb.frame_err   = err_q;

endmodule

// File: tb/tb_ps2_keycode.sv
// Directed bench for ps2_keycode: drives PS/2 frames bit by bit and checks the keycode bus.
`timescale 1ns/1ps

module tb_ps2_keycode;

  localparam int unsigned HALF = 6;  // Clk cycles per PS/2 clock half-period

  logic Clk;
  logic Reset_n;
  logic ps2_clk;
  logic ps2_data;

  int checks = 0;
  int errors = 0;
  int chg_cnt = 0;
  int err_cnt = 0;

  ps2_keycode_if kb ();

  ps2_keycode dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kb       (kb.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Count output pulses, sampled away from the active edge
  always @(negedge Clk) begin
    if (kb.keycode_chg) chg_cnt++;
    if (kb.frame_err)   err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) tick();
    ps2_clk = 1'b0;
    repeat (HALF) tick();
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(bad_par ? ^b : ~^b);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (8) tick();
  endtask

  int c0;
  int e0;

  initial begin
    Reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) tick();
    check("rst_keycode", 32'(kb.keycode), 32'h00);
    check("rst_chg", 32'(kb.keycode_chg), 32'h0);
    check("rst_err", 32'(kb.frame_err), 32'h0);
    Reset_n = 1'b1;
    repeat (3) tick();

    // 1: reset mid-frame drops the frame and the pending break prefix
    send_frame(8'h1D, 1'b0);
    check("t1_make_w", 32'(kb.keycode), 32'h1A);
    send_frame(8'hF0, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    Reset_n = 1'b0;
    repeat (2) tick();
    check("t1_rst_keycode", 32'(kb.keycode), 32'h00);
    Reset_n  = 1'b1;
    ps2_data = 1'b1;
    repeat (4) tick();
    send_frame(8'h1D, 1'b0);
    check("t1_after_rst", 32'(kb.keycode), 32'h1A);

    // 2: make/break with exactly two change pulses; typematic repeat is silent
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    check("t2_clear", 32'(kb.keycode), 32'h00);
    c0 = chg_cnt;
    send_frame(8'h1D, 1'b0);
    check("t2_make", 32'(kb.keycode), 32'h1A);
    send_frame(8'h1D, 1'b0);
    check("t2_repeat_chg", 32'(chg_cnt - c0), 32'd1);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    check("t2_break", 32'(kb.keycode), 32'h00);
    check("t2_chg_cnt", 32'(chg_cnt - c0), 32'd2);

    // 3: releasing a key that is no longer held leaves keycode alone
    send_frame(8'h1D, 1'b0);
    check("t3_w", 32'(kb.keycode), 32'h1A);
    send_frame(8'h1C, 1'b0);
    check("t3_a", 32'(kb.keycode), 32'h04);
    c0 = chg_cnt;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    check("t3_stale_break", 32'(kb.keycode), 32'h04);
    check("t3_no_chg", 32'(chg_cnt - c0), 32'd0);
    send_frame(8'h15, 1'b0);
    check("t3_untracked", 32'(kb.keycode), 32'h04);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("t3_release_a", 32'(kb.keycode), 32'h00);

    // 4: parity error discards the byte
    e0 = err_cnt;
    send_frame(8'h1D, 1'b1);
    check("t4_err", 32'(err_cnt - e0), 32'd1);
    check("t4_keycode", 32'(kb.keycode), 32'h00);
    send_frame(8'h1B, 1'b0);
    check("t4_s", 32'(kb.keycode), 32'h16);
    send_frame(8'h29, 1'b0);
    check("t4_space", 32'(kb.keycode), 32'h2C);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h29, 1'b0);
    check("t4_release", 32'(kb.keycode), 32'h00);

    // 5: frame stalls after five data bits and times out
    e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    repeat (49800) tick();
    check("t5_no_early_to", 32'(err_cnt - e0), 32'd0);
    repeat (300) tick();
    check("t5_timeout", 32'(err_cnt - e0), 32'd1);
    check("t5_keycode", 32'(kb.keycode), 32'h00);
    send_frame(8'h23, 1'b0);
    check("t5_d", 32'(kb.keycode), 32'h07);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h23, 1'b0);
    check("t5_release", 32'(kb.keycode), 32'h00);

    // 6: extended arrow codes
    c0 = chg_cnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
`ifdef ARROW_KEYS_EN
    check("t6_up", 32'(kb.keycode), 32'h1A);
`else
    check("t6_up", 32'(kb.keycode), 32'h00);
`endif
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("t6_up_rel", 32'(kb.keycode), 32'h00);
`ifdef ARROW_KEYS_EN
    check("t6_chg", 32'(chg_cnt - c0), 32'd2);
`else
    check("t6_chg", 32'(chg_cnt - c0), 32'd0);
`endif
    // Releasing Up while W is held: aliases only with arrows enabled
    send_frame(8'h1D, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
`ifdef ARROW_KEYS_EN
    check("t6_alias_rel", 32'(kb.keycode), 32'h00);
`else
    check("t6_alias_rel", 32'(kb.keycode), 32'h1A);
`endif
    // Prefixes are cleared after the extended byte: plain 1B is a make
    send_frame(8'h1B, 1'b0);
    check("t6_prefix_clr", 32'(kb.keycode), 32'h16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
